// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - circular commit-trace buffer with PC trigger, post-trigger window and drain port
module cpu_trace_buffer #(
  parameter int DATA_W    = 32,
  parameter int AW        = 4,
  parameter int POST_TRIG = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_pc,
  input  logic              cpu_valid,
  input  logic [DATA_W-1:0] cpu_pc,
  input  logic [31:0]       cpu_inst,
  input  logic              cpu_reg_write,
  input  logic [4:0]        cpu_write_reg,
  input  logic [DATA_W-1:0] cpu_write_data,
  input  logic              cpu_mem_write,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_pc,
  output logic [31:0]       rd_inst,
  output logic [DATA_W-1:0] rd_wdata,
  output logic [4:0]        rd_wreg,
  output logic [1:0]        rd_flags,
  output logic [1:0]        state,
  output logic [AW:0]       count,
  output logic              triggered
);

  localparam int DEPTH = 2 ** AW;
  localparam int ENT_W = 2 * DATA_W + 32 + 5 + 2;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_L   = AW'(POST_TRIG);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    CAPTURE = 2'b10,
    DONE    = 2'b11
  } state_e;

  state_e            state_q;
  logic [AW-1:0]     wp_q, rp_q, post_q;
  logic [AW:0]       count_q;
  logic              triggered_q;
  logic [ENT_W-1:0]  mem_q [DEPTH];

  logic              capturing, cap_en, trig_hit, full;
  logic [ENT_W-1:0]  entry_d, head;

  assign capturing = (state_q == ARMED) || (state_q == CAPTURE);
  // arm wins over capture: the entry presented in an arm cycle is dropped
  assign cap_en    = cpu_valid && capturing && !arm;
  assign trig_hit  = trig_en ? (cpu_pc == trig_pc) : 1'b1;
  assign full      = (count_q == FULL_CNT);
  assign entry_d   = {cpu_pc, cpu_inst, cpu_write_data, cpu_write_reg, cpu_mem_write, cpu_reg_write};

  always_ff @(posedge clk) begin
    if (cap_en) begin
      mem_q[wp_q] <= entry_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wp_q        <= '0;
      rp_q        <= '0;
      post_q      <= '0;
      count_q     <= '0;
      triggered_q <= 1'b0;
    end else if (arm && state_q != DONE) begin
      state_q     <= ARMED;
      wp_q        <= '0;
      rp_q        <= '0;
      post_q      <= '0;
      count_q     <= '0;
      triggered_q <= 1'b0;
    end else begin
      // when full, the oldest entry is overwritten so rp follows wp
      if (cap_en) begin
        wp_q <= wp_q + 1'b1;
        if (full) rp_q <= rp_q + 1'b1;
        else      count_q <= count_q + 1'b1;
      end
      case (state_q)
        ARMED: begin
          if (cpu_valid && trig_hit) begin
            triggered_q <= 1'b1;
            post_q      <= POST_L;
            state_q     <= (POST_TRIG == 0) ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (cpu_valid) begin
            post_q <= post_q - 1'b1;
            if (post_q == AW'(1)) state_q <= DONE;
          end
        end
        DONE: begin
          if (rd_valid && rd_ready) begin
            rp_q    <= rp_q + 1'b1;
            count_q <= count_q - 1'b1;
            if (count_q == (AW+1)'(1)) state_q <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign head      = mem_q[rp_q];
  assign rd_valid  = (state_q == DONE) && (count_q != '0);
  assign rd_pc     = head[ENT_W-1 -: DATA_W];
  assign rd_inst   = head[DATA_W+7+32-1 -: 32];
  assign rd_wdata  = head[DATA_W+7-1 -: DATA_W];
  assign rd_wreg   = head[6:2];
  assign rd_flags  = head[1:0];
  assign state     = state_q;
  assign count     = count_q;
  assign triggered = triggered_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb/tb_cpu_trace_buffer.sv - directed self-checking bench for cpu_trace_buffer
module tb_cpu_trace_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        arm_a = 1'b0, arm_b = 1'b0;
  logic        trig_en = 1'b1;
  logic [31:0] trig_pc = '0;
  logic        cpu_valid = 1'b0;
  logic [31:0] cpu_pc = '0, cpu_inst = '0, cpu_write_data = '0;
  logic        cpu_reg_write = 1'b0, cpu_mem_write = 1'b0;
  logic [4:0]  cpu_write_reg = '0;
  logic        rd_ready_a = 1'b0, rd_ready_b = 1'b0;

  logic        rd_valid_a, rd_valid_b, triggered_a, triggered_b;
  logic [31:0] rd_pc_a, rd_pc_b, rd_inst_a, rd_inst_b, rd_wdata_a, rd_wdata_b;
  logic [4:0]  rd_wreg_a, rd_wreg_b, count_a, count_b;
  logic [1:0]  rd_flags_a, rd_flags_b, state_a, state_b;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  cpu_trace_buffer #(.DATA_W(32), .AW(4), .POST_TRIG(8)) dut_a (
    .clk(clk), .reset(reset), .arm(arm_a), .trig_en(trig_en), .trig_pc(trig_pc),
    .cpu_valid(cpu_valid), .cpu_pc(cpu_pc), .cpu_inst(cpu_inst),
    .cpu_reg_write(cpu_reg_write), .cpu_write_reg(cpu_write_reg),
    .cpu_write_data(cpu_write_data), .cpu_mem_write(cpu_mem_write),
    .rd_valid(rd_valid_a), .rd_ready(rd_ready_a), .rd_pc(rd_pc_a), .rd_inst(rd_inst_a),
    .rd_wdata(rd_wdata_a), .rd_wreg(rd_wreg_a), .rd_flags(rd_flags_a),
    .state(state_a), .count(count_a), .triggered(triggered_a)
  );

  cpu_trace_buffer #(.DATA_W(32), .AW(4), .POST_TRIG(0)) dut_b (
    .clk(clk), .reset(reset), .arm(arm_b), .trig_en(trig_en), .trig_pc(trig_pc),
    .cpu_valid(cpu_valid), .cpu_pc(cpu_pc), .cpu_inst(cpu_inst),
    .cpu_reg_write(cpu_reg_write), .cpu_write_reg(cpu_write_reg),
    .cpu_write_data(cpu_write_data), .cpu_mem_write(cpu_mem_write),
    .rd_valid(rd_valid_b), .rd_ready(rd_ready_b), .rd_pc(rd_pc_b), .rd_inst(rd_inst_b),
    .rd_wdata(rd_wdata_b), .rd_wreg(rd_wreg_b), .rd_flags(rd_flags_b),
    .state(state_b), .count(count_b), .triggered(triggered_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] f_inst(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  function automatic logic [31:0] f_wdata(input logic [31:0] pc);
    return pc + 32'h1000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] pc, input logic v);
    cpu_valid      = v;
    cpu_pc         = pc;
    cpu_inst       = f_inst(pc);
    cpu_write_data = f_wdata(pc);
    cpu_write_reg  = pc[6:2];
    cpu_mem_write  = pc[3];
    cpu_reg_write  = pc[2];
    step();
  endtask

  task automatic arm_dut_a();
    arm_a = 1'b1;
    cpu_valid = 1'b0;
    step();
    arm_a = 1'b0;
    check("arm_state", state_a, 2'b01);
    check("arm_count", count_a, 0);
    check("arm_trig", triggered_a, 0);
  endtask

  task automatic drain_a(input logic [31:0] first_pc, input int n, input int stride, input bit patterned);
    int popped = 0;
    int cyc = 0;
    logic [31:0] pc;
    bit rdy;
    pc = first_pc;
    while (popped < n && cyc < 4 * n + 8) begin
      rdy = patterned ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      rd_ready_a = rdy;
      arm_a = patterned && (cyc == 1);
      check("drain_state", state_a, 2'b11);
      check("drain_valid", rd_valid_a, 1);
      check("drain_count", count_a, n - popped);
      check("drain_pc", rd_pc_a, pc);
      check("drain_inst", rd_inst_a, f_inst(pc));
      check("drain_wdata", rd_wdata_a, f_wdata(pc));
      check("drain_wreg", rd_wreg_a, pc[6:2]);
      check("drain_flags", rd_flags_a, {pc[3], pc[2]});
      step();
      if (rdy) begin
        popped++;
        pc += stride;
      end
      cyc++;
    end
    rd_ready_a = 1'b0;
    arm_a = 1'b0;
    check("drain_popped", popped, n);
    check("drain_end_state", state_a, 2'b00);
    check("drain_end_valid", rd_valid_a, 0);
    check("drain_end_count", count_a, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #3;
    check("rst_state", state_a, 2'b00);
    check("rst_count", count_a, 0);
    check("rst_valid", rd_valid_a, 0);
    check("rst_trig", triggered_a, 0);
    step();
    reset = 1'b1;
    step();

    // full buffer wraps: 17 entries 0x00..0x40, oldest dropped
    trig_en = 1'b1;
    trig_pc = 32'h20;
    arm_dut_a();
    for (int k = 0; k <= 16; k++) begin
      present(32'(k * 4), 1'b1);
      if (k == 7) begin
        check("t1_pre_state", state_a, 2'b01);
        check("t1_pre_trig", triggered_a, 0);
      end
      if (k == 8) begin
        check("t1_trig_state", state_a, 2'b10);
        check("t1_trig", triggered_a, 1);
      end
      if (k == 15) check("t1_cap_state", state_a, 2'b10);
    end
    cpu_valid = 1'b0;
    check("t1_done_state", state_a, 2'b11);
    check("t1_done_count", count_a, 16);
    check("t1_done_valid", rd_valid_a, 1);
    drain_a(32'h04, 16, 4, 1'b0);

    // early trigger, stalled drain with an ignored arm pulse
    trig_pc = 32'h08;
    arm_dut_a();
    for (int k = 0; k <= 10; k++) present(32'(k * 4), 1'b1);
    cpu_valid = 1'b0;
    check("t2_state", state_a, 2'b11);
    check("t2_count", count_a, 11);
    drain_a(32'h00, 11, 4, 1'b1);

    // qualifier toggling: only even steps are valid
    trig_pc = 32'h20;
    arm_dut_a();
    for (int k = 0; k <= 24; k++) begin
      present(32'(k * 4), (k % 2) == 0);
      if (k == 23) check("t3_cap_state", state_a, 2'b10);
    end
    cpu_valid = 1'b0;
    check("t3_state", state_a, 2'b11);
    check("t3_count", count_a, 13);
    drain_a(32'h00, 13, 8, 1'b0);

    // POST_TRIG=0, trigger on first committed entry
    trig_en = 1'b0;
    arm_b = 1'b1;
    cpu_valid = 1'b0;
    step();
    arm_b = 1'b0;
    check("t4_arm_state", state_b, 2'b01);
    present(32'h100, 1'b1);
    check("t4_state", state_b, 2'b11);
    check("t4_count", count_b, 1);
    check("t4_trig", triggered_b, 1);
    present(32'h104, 1'b1);
    cpu_valid = 1'b0;
    check("t4_no_cap", count_b, 1);
    check("t4_valid", rd_valid_b, 1);
    check("t4_pc", rd_pc_b, 32'h100);
    check("t4_inst", rd_inst_b, f_inst(32'h100));
    rd_ready_b = 1'b1;
    step();
    rd_ready_b = 1'b0;
    check("t4_end_state", state_b, 2'b00);
    check("t4_end_valid", rd_valid_b, 0);
    check("t4_a_idle", count_a, 0);

    // arm priority over capture, then async reset mid-capture
    trig_en = 1'b1;
    trig_pc = 32'h20;
    arm_dut_a();
    present(32'h00, 1'b1);
    present(32'h04, 1'b1);
    check("t5_count2", count_a, 2);
    arm_a = 1'b1;
    cpu_valid = 1'b1;
    cpu_pc = 32'h08;
    step();
    arm_a = 1'b0;
    check("t5_rearm_count", count_a, 0);
    check("t5_rearm_state", state_a, 2'b01);
    for (int k = 4; k <= 9; k++) present(32'(k * 4), 1'b1);
    cpu_valid = 1'b0;
    check("t5_cap_state", state_a, 2'b10);
    check("t5_cap_count", count_a, 6);
    #3 reset = 1'b0;
    #1;
    check("t5_rst_state", state_a, 2'b00);
    check("t5_rst_count", count_a, 0);
    check("t5_rst_valid", rd_valid_a, 0);
    check("t5_rst_trig", triggered_a, 0);
    #1 reset = 1'b1;
    step();

    trig_en = 1'b0;
    arm_dut_a();
    present(32'h200, 1'b1);
    check("t5_restart_state", state_a, 2'b10);
    check("t5_restart_trig", triggered_a, 1);
    for (int k = 1; k <= 8; k++) present(32'h200 + 32'(k * 4), 1'b1);
    cpu_valid = 1'b0;
    check("t5_done_state", state_a, 2'b11);
    check("t5_done_count", count_a, 9);
    drain_a(32'h200, 9, 4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
